// File: rtl/dot6_stream_collector.sv
// ---------------------------------------------------------------------------
// dot6_stream_collector
//
// Front and back end for the hard sum-of-6 8x8 dot unit. Operand chunks
// (six signed 8-bit pairs) arrive over a valid/ready handshake. They are
// forwarded to the dot unit, which has a fixed latency and cannot stall. A
// tag delay line of the same depth marks which returning partial sums are
// real and which close a vector. The partial sums of each vector are
// accumulated, and finished results are queued in a small show-ahead FIFO.
// Input is throttled by credits. A vector end is only accepted when a FIFO
// slot is guaranteed for it, so a result can never arrive at a full FIFO.
//
// Ports:
//   clk        sole clock
//   rst_n      asynchronous active-low reset; a partial vector is discarded
//   in_valid   operand chunk valid
//   in_ready   chunk accepted when in_valid & in_ready (depends on state only)
//   in_a/in_b  six signed operands each, element k at bits [8k+7:8k]
//   in_last    chunk closes its vector
//   dot_a/b    operands to the dot unit, all zero in cycles with no accept
//   dot_sum    signed partial sum returning DOT_LAT cycles after dot_a/dot_b
//   out_valid  FIFO head valid
//   out_ready  consumer pop
//   out_data   signed vector dot product (wraps modulo 2^ACC_W)
//   out_len    number of chunks in that vector (wraps modulo 2^LEN_W)
//
// DEPTH must be a power of two, so the FIFO pointers wrap on their own.
// ---------------------------------------------------------------------------
module dot6_stream_collector #(
    parameter int DOT     = 6,
    parameter int SIZEA   = 8,
    parameter int SIZEB   = 8,
    parameter int DOT_LAT = 4,
    parameter int ACC_W   = 32,
    parameter int LEN_W   = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DOT*SIZEA-1:0]     in_a,
    input  logic [DOT*SIZEB-1:0]     in_b,
    input  logic                     in_last,
    output logic [DOT*SIZEA-1:0]     dot_a,
    output logic [DOT*SIZEB-1:0]     dot_b,
    input  logic [SIZEA+SIZEB+1:0]   dot_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [LEN_W-1:0]         out_len
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RES_W = $clog2(DEPTH + DOT_LAT + 1);

    logic                accept;

    logic [DOT_LAT-1:0]  tag_v;
    logic [DOT_LAT-1:0]  tag_l;
    logic                tail_v;
    logic                tail_l;

    logic [ACC_W-1:0]    acc;
    logic [LEN_W-1:0]    len;
    logic                first;
    logic [ACC_W-1:0]    sum;
    logic [LEN_W-1:0]    len_next;

    logic [ACC_W-1:0]    mem_data [DEPTH];
    logic [LEN_W-1:0]    mem_len  [DEPTH];
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [CNT_W-1:0]    count;
    logic                push;
    logic                pop;

    logic [RES_W-1:0]    inflight_last;
    logic [RES_W-1:0]    reserved;

    // Credit check: every vector end already in the tag line owns a FIFO
    // slot it will occupy later, so it is counted as if already stored.
    // Non-last chunks are held to the same rule to keep in_ready independent
    // of in_last.
    always_comb begin
        inflight_last = '0;
        for (int i = 0; i < DOT_LAT; i++) begin
            inflight_last = inflight_last + RES_W'(tag_l[i]);
        end
        reserved = RES_W'(count) + inflight_last;
        in_ready = (reserved < RES_W'(DEPTH));
    end

    // Operands go to the dot unit only in accept cycles. Idle cycles push
    // zeros, and their results are ignored because their tag is not valid.
    always_comb begin
        accept = in_valid & in_ready;
        dot_a  = accept ? in_a : '0;
        dot_b  = accept ? in_b : '0;
    end

    // Tag delay line. It matches the dot unit latency, so the tail stage
    // describes the dot_sum present in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_l <= '0;
        end else begin
            tag_v[0] <= accept;
            tag_l[0] <= accept & in_last;
            for (int i = 1; i < DOT_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
            end
        end
    end

    assign tail_v = tag_v[DOT_LAT-1];
    assign tail_l = tag_l[DOT_LAT-1];

    // The running sum restarts from zero on the first chunk of a vector
    // instead of clearing acc. This lets a new vector start the cycle right
    // after a last chunk.
    always_comb begin
        sum      = (first ? '0 : acc) + ACC_W'($signed(dot_sum));
        len_next = len + LEN_W'(1);
        push     = tail_v & tail_l;
    end

    // Accumulator and chunk counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            len   <= '0;
            first <= 1'b1;
        end else if (tail_v) begin
            if (tail_l) begin
                acc   <= '0;
                len   <= '0;
                first <= 1'b1;
            end else begin
                acc   <= sum;
                len   <= len_next;
                first <= 1'b0;
            end
        end
    end

    // FIFO storage. It has no reset because the outputs are masked while
    // the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr] <= sum;
            mem_len[wptr]  <= len_next;
        end
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle leave
    // the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Show-ahead head of the FIFO.
    always_comb begin
        out_valid = (count != '0);
        pop       = out_valid & out_ready;
        out_data  = out_valid ? mem_data[rptr] : '0;
        out_len   = out_valid ? mem_len[rptr]  : '0;
    end

    // Credits must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_dot6_stream_collector.sv
// ---------------------------------------------------------------------------
// Testbench for dot6_stream_collector.
// A behavioural dot unit (a plain sum of six products delayed by DOT_LAT
// cycles) sits beside each DUT. The reference model tracks each vector as a
// running integer sum and a chunk count, and queues the expected results in
// order. A second instance with ACC_W=18 sees the same stimulus and is used
// for the wrap scenario. Inputs are driven #1 after the rising edge, and
// everything is sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dot6_stream_collector;

    localparam int DOT     = 6;
    localparam int SIZEA   = 8;
    localparam int SIZEB   = 8;
    localparam int DOT_LAT = 4;
    localparam int ACC_W   = 32;
    localparam int LEN_W   = 8;
    localparam int DEPTH   = 4;
    localparam int SUM_W   = SIZEA + SIZEB + 2;
    localparam int WRAP_W  = 18;
    localparam int OPW     = DOT * SIZEA;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [OPW-1:0]    in_a;
    logic [OPW-1:0]    in_b;
    logic              in_last;
    logic [OPW-1:0]    dot_a;
    logic [OPW-1:0]    dot_b;
    logic [SUM_W-1:0]  dot_sum;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [LEN_W-1:0]  out_len;

    logic              w_in_ready;
    logic [OPW-1:0]    w_dot_a;
    logic [OPW-1:0]    w_dot_b;
    logic [SUM_W-1:0]  w_dot_sum;
    logic              w_out_valid;
    logic [WRAP_W-1:0] w_out_data;
    logic [LEN_W-1:0]  w_out_len;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint cur_sum;
    int     cur_len;
    logic [ACC_W-1:0] exp_data [$];
    logic [LEN_W-1:0] exp_len  [$];
    int     pop_cnt;
    logic [WRAP_W-1:0] w_last_data;
    logic [LEN_W-1:0]  w_last_len;

    // Values captured at the most recent falling edge
    logic s_in_ready, s_acc, s_out_valid, s_pop;
    logic [ACC_W-1:0] s_out_data;
    logic [LEN_W-1:0] s_out_len;
    logic rand_ready;

    always #5 clk = ~clk;

    dot6_stream_collector #(
        .DOT(DOT), .SIZEA(SIZEA), .SIZEB(SIZEB), .DOT_LAT(DOT_LAT),
        .ACC_W(ACC_W), .LEN_W(LEN_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .dot_a(dot_a), .dot_b(dot_b), .dot_sum(dot_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_len(out_len)
    );

    dot6_stream_collector #(
        .DOT(DOT), .SIZEA(SIZEA), .SIZEB(SIZEB), .DOT_LAT(DOT_LAT),
        .ACC_W(WRAP_W), .LEN_W(LEN_W), .DEPTH(DEPTH)
    ) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .dot_a(w_dot_a), .dot_b(w_dot_b), .dot_sum(w_dot_sum),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_len(w_out_len)
    );

    function automatic int dot6(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        int s;
        s = 0;
        for (int k = 0; k < DOT; k++) begin
            s += int'($signed(a[8*k +: 8])) * int'($signed(b[8*k +: 8]));
        end
        return s;
    endfunction

    // Behavioural dot units: fixed latency and no enable
    logic [SUM_W-1:0] pipe_m [DOT_LAT];
    logic [SUM_W-1:0] pipe_w [DOT_LAT];
    always @(posedge clk) begin
        pipe_m[0] <= SUM_W'(dot6(dot_a, dot_b));
        pipe_w[0] <= SUM_W'(dot6(w_dot_a, w_dot_b));
        for (int i = 1; i < DOT_LAT; i++) begin
            pipe_m[i] <= pipe_m[i-1];
            pipe_w[i] <= pipe_w[i-1];
        end
    end
    assign dot_sum   = pipe_m[DOT_LAT-1];
    assign w_dot_sum = pipe_w[DOT_LAT-1];

    // Sample at the falling edge, update the model and score pops
    task automatic sample();
        logic [OPW-1:0] ea, eb;
        logic [ACC_W-1:0] ed;
        logic [LEN_W-1:0] el;
        if (!rst_n) return;
        s_in_ready  = in_ready;
        s_acc       = in_valid && in_ready;
        s_out_valid = out_valid;
        s_out_data  = out_data;
        s_out_len   = out_len;
        s_pop       = out_valid && out_ready;
        ea = s_acc ? in_a : '0;
        eb = s_acc ? in_b : '0;
        checks++;
        if (dot_a !== ea || dot_b !== eb || w_dot_a !== ea || w_dot_b !== eb || w_in_ready !== in_ready) begin
            errors++;
            $display("[TB] FAIL dot_drive dot_a=%h dot_b=%h required %h %h", dot_a, dot_b, ea, eb);
        end
        if (s_acc) begin
            cur_sum += longint'(dot6(in_a, in_b));
            cur_len++;
            if (in_last) begin
                exp_data.push_back(ACC_W'(cur_sum));
                exp_len.push_back(LEN_W'(cur_len));
                cur_sum = 0;
                cur_len = 0;
            end
        end
        if (w_out_valid && out_ready) begin
            w_last_data = w_out_data;
            w_last_len  = w_out_len;
        end
        if (s_pop) begin
            checks++;
            pop_cnt++;
            if (exp_data.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pop data=%0d len=%0d required no result", out_data, out_len);
            end else begin
                ed = exp_data.pop_front();
                el = exp_len.pop_front();
                if (out_data !== ed || out_len !== el) begin
                    errors++;
                    $display("[TB] FAIL result data=%0d len=%0d required data=%0d len=%0d",
                             $signed(out_data), out_len, $signed(ed), el);
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic send_chunk(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                              input logic last, output int waited);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        waited   = 0;
        forever begin
            cycle();
            if (s_acc) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout waited=%0d required acceptance", waited);
                break;
            end
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        forever begin
            cycle();
            lat++;
            if (s_out_valid) break;
            if (lat > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL out_timeout cycles=%0d required out_valid", lat);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle();
        n = 0;
        while (exp_data.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        repeat (DOT_LAT + 2) cycle();
        checks++;
        if (exp_data.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain left=%0d required 0", exp_data.size());
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
            out_len !== '0 || dot_a !== '0 || dot_b !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values in_ready=%b out_valid=%b data=%0d len=%0d dot_a=%h required 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_len, dot_a);
        end
    endtask

    task automatic test_single();
        int w, lat;
        out_ready = 1'b1;
        send_chunk(48'h06_05_04_03_02_01, 48'h01_01_01_01_01_01, 1'b1, w);
        idle();
        wait_out(lat);
        checks++;
        if (lat != DOT_LAT + 1) begin
            errors++;
            $display("[TB] FAIL single_latency got=%0d required %0d", lat, DOT_LAT + 1);
        end
        checks++;
        if (s_out_data !== 32'd21 || s_out_len !== 8'd1) begin
            errors++;
            $display("[TB] FAIL single_result data=%0d len=%0d required 21 1", s_out_data, s_out_len);
        end
        drain();
    endtask

    task automatic test_neg_extremes();
        int w, lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_chunk({6{8'h80}}, {6{8'h80}}, (i == 2), w);
        end
        idle();
        wait_out(lat);
        checks++;
        if (s_out_data !== 32'd294912 || s_out_len !== 8'd3) begin
            errors++;
            $display("[TB] FAIL neg_extremes data=%0d len=%0d required 294912 3", s_out_data, s_out_len);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int w, held, first_pop;
        rand_ready = 1'b0;
        out_ready  = 1'b0;
        for (int v = 0; v < DEPTH; v++) begin
            send_chunk(OPW'({$urandom(), $urandom()}), OPW'({$urandom(), $urandom()}), 1'b1, w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("[TB] FAIL bp_fill_wait vector=%0d waited=%0d required 0", v, w);
            end
        end
        in_valid = 1'b1;
        in_a     = OPW'({$urandom(), $urandom()});
        in_b     = OPW'({$urandom(), $urandom()});
        in_last  = 1'b1;
        cycle();
        checks++;
        if (s_in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_in_ready_fall in_ready=%b required 0", s_in_ready);
        end
        held = 0;
        repeat (8) begin
            cycle();
            if (s_acc) held++;
        end
        checks++;
        if (held != 0 || s_out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_hold accepts=%0d out_valid=%b required 0 1", held, s_out_valid);
        end
        first_pop = pop_cnt;
        out_ready = 1'b1;
        cycle();
        checks++;
        if (s_pop !== 1'b1 || s_acc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_first_pop pop=%b accept=%b required 1 0", s_pop, s_acc);
        end
        cycle();
        checks++;
        if (s_acc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_fifth_accept accept=%b required 1", s_acc);
        end
        drain();
        checks++;
        if (pop_cnt - first_pop != DEPTH + 1) begin
            errors++;
            $display("[TB] FAIL bp_pop_count got=%0d required %0d", pop_cnt - first_pop, DEPTH + 1);
        end
    endtask

    task automatic test_back_to_back();
        int w, wsum;
        out_ready = 1'b1;
        wsum = 0;
        send_chunk(OPW'({$urandom(), $urandom()}), OPW'({$urandom(), $urandom()}), 1'b1, w);
        send_chunk(OPW'({$urandom(), $urandom()}), OPW'({$urandom(), $urandom()}), 1'b0, w);
        wsum += w;
        send_chunk(OPW'({$urandom(), $urandom()}), OPW'({$urandom(), $urandom()}), 1'b1, w);
        wsum += w;
        checks++;
        if (wsum != 0) begin
            errors++;
            $display("[TB] FAIL b2b_stall waited=%0d required 0", wsum);
        end
        drain();
    endtask

    task automatic test_random_stream();
        int w, start, nlen;
        start = pop_cnt;
        rand_ready = 1'b1;
        for (int v = 0; v < 40; v++) begin
            nlen = $urandom_range(1, 4);
            for (int c = 0; c < nlen; c++) begin
                send_chunk(OPW'({$urandom(), $urandom()}), OPW'({$urandom(), $urandom()}), (c == nlen - 1), w);
            end
            if ($urandom_range(0, 3) == 0) begin
                idle();
                cycle();
            end
        end
        drain();
        // Continuous single-chunk stream with the consumer always ready
        for (int v = 0; v < 20; v++) begin
            send_chunk(OPW'({$urandom(), $urandom()}), OPW'({$urandom(), $urandom()}), 1'b1, w);
        end
        drain();
        checks++;
        if (pop_cnt - start != 60) begin
            errors++;
            $display("[TB] FAIL stream_pop_count got=%0d required 60", pop_cnt - start);
        end
    endtask

    task automatic test_reset_mid();
        int w, lat;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            send_chunk(OPW'({$urandom(), $urandom()}), OPW'({$urandom(), $urandom()}), 1'b0, w);
        end
        idle();
        rst_n = 1'b0;
        cur_sum = 0;
        cur_len = 0;
        exp_data.delete();
        exp_len.delete();
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_chunk({6{8'h02}}, {6{8'h02}}, 1'b1, w);
        idle();
        wait_out(lat);
        checks++;
        if (s_out_data !== 32'd24 || s_out_len !== 8'd1) begin
            errors++;
            $display("[TB] FAIL reset_mid_result data=%0d len=%0d required 24 1", s_out_data, s_out_len);
        end
        drain();
    endtask

    task automatic test_wrap();
        int w;
        logic [WRAP_W-1:0] expw;
        expw = WRAP_W'(-65536);
        out_ready = 1'b1;
        send_chunk({6{8'h80}}, {6{8'h80}}, 1'b0, w);
        send_chunk({6{8'h80}}, {6{8'h80}}, 1'b1, w);
        drain();
        checks++;
        if (w_last_data !== expw || w_last_len !== 8'd2) begin
            errors++;
            $display("[TB] FAIL wrap data=%0d len=%0d required -65536 2", $signed(w_last_data), w_last_len);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        rand_ready = 1'b0;
        cur_sum    = 0;
        cur_len    = 0;
        pop_cnt    = 0;
        w_last_data = '0;
        w_last_len  = '0;
        idle();
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_single();
        test_neg_extremes();
        test_backpressure();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog time=%0t required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
